// File: rtl/phys_reg_free_list.sv
// Free list of physical register tags for rename.
// Circular FIFO: dispatch consumes the head tag, ROB commit returns freed tags at the tail.
// Per-column head checkpoints let a mispredict restore the head in a single cycle.
module phys_reg_free_list #(
   parameter int DEPTH        = 32,
   parameter int TAG_WIDTH    = 6,
   parameter int FIRST_FREE   = 32,
   parameter int CKPT_COLUMNS = 4
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            dispatch_dequeue,
   output logic [TAG_WIDTH-1:0]            free_reg_tag,
   output logic                            empty,
   output logic                            full,
   input  logic                            commit_enqueue,
   input  logic [TAG_WIDTH-1:0]            commit_tag,
   input  logic                            ckpt_save,
   input  logic [$clog2(CKPT_COLUMNS)-1:0] ckpt_save_column,
   input  logic                            ckpt_restore,
   input  logic [$clog2(CKPT_COLUMNS)-1:0] ckpt_restore_column,
   output logic                            overflow_error
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [TAG_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [PTR_W-1:0]     head_next;
   logic [PTR_W-1:0]     tail_next;
   logic [PTR_W-1:0]     ckpt [CKPT_COLUMNS];
   logic                 deq_ok;
   logic                 enq_ok;

   assign empty        = (head == tail);
   assign full         = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
   assign free_reg_tag = mem[head[IDX_W-1:0]];

   // Accept decisions and next pointers; a restore overrides any dequeue on the head.
   always_comb begin
      deq_ok    = dispatch_dequeue && !empty && !ckpt_restore;
      enq_ok    = commit_enqueue && (!full || deq_ok);
      head_next = head + PTR_W'(deq_ok);
      if (ckpt_restore) begin
         head_next = ckpt[ckpt_restore_column];
      end
      tail_next = tail + PTR_W'(enq_ok);
   end

   // Pointer, checkpoint and error-flag registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head           <= '0;
         tail           <= {1'b1, {IDX_W{1'b0}}};
         overflow_error <= 1'b0;
         for (int c = 0; c < CKPT_COLUMNS; c++) begin
            ckpt[c] <= '0;
         end
      end else begin
         head <= head_next;
         tail <= tail_next;
         if (ckpt_save) begin
            ckpt[ckpt_save_column] <= head_next;
         end
         if (commit_enqueue && !enq_ok) begin
            overflow_error <= 1'b1;
         end
      end
   end

   // Tag storage; reset preloads the tags not mapped to architectural registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= TAG_WIDTH'(FIRST_FREE + i);
         end
      end else if (enq_ok) begin
         mem[tail[IDX_W-1:0]] <= commit_tag;
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed test of the physical register free list.
module tb_phys_reg_free_list;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       dispatch_dequeue;
   logic [5:0] free_reg_tag;
   logic       empty;
   logic       full;
   logic       commit_enqueue;
   logic [5:0] commit_tag;
   logic       ckpt_save;
   logic [1:0] ckpt_save_column;
   logic       ckpt_restore;
   logic [1:0] ckpt_restore_column;
   logic       overflow_error;

   int total = 0;
   int bad   = 0;

   phys_reg_free_list dut (
      .CLK                 (CLK),
      .nRST                (nRST),
      .dispatch_dequeue    (dispatch_dequeue),
      .free_reg_tag        (free_reg_tag),
      .empty               (empty),
      .full                (full),
      .commit_enqueue      (commit_enqueue),
      .commit_tag          (commit_tag),
      .ckpt_save           (ckpt_save),
      .ckpt_save_column    (ckpt_save_column),
      .ckpt_restore        (ckpt_restore),
      .ckpt_restore_column (ckpt_restore_column),
      .overflow_error      (overflow_error)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      dispatch_dequeue    = 1'b0;
      commit_enqueue      = 1'b0;
      commit_tag          = '0;
      ckpt_save           = 1'b0;
      ckpt_save_column    = '0;
      ckpt_restore        = 1'b0;
      ckpt_restore_column = '0;
   endtask

   // Asynchronous reset applied between edges, outputs checked before any clock.
   task automatic do_reset();
      idle();
      nRST = 1'b0;
      #2;
      check("rst_tag", 32'(free_reg_tag), 32);
      check("rst_empty", 32'(empty), 0);
      check("rst_full", 32'(full), 1);
      check("rst_ovf", 32'(overflow_error), 0);
      tick();
      nRST = 1'b1;
      #1;
   endtask

   task automatic deq_n(input int n);
      dispatch_dequeue = 1'b1;
      repeat (n) tick();
      dispatch_dequeue = 1'b0;
   endtask

   initial begin
      logic [5:0] q[$];
      int         n;
      nRST = 1'b1;
      idle();
      #3;
      do_reset();

      // 1: drain in order
      dispatch_dequeue = 1'b1;
      for (int i = 0; i < 32; i++) begin
         check("drain_tag", 32'(free_reg_tag), 32'(32 + i));
         tick();
      end
      dispatch_dequeue = 1'b0;
      check("drained_empty", 32'(empty), 1);
      check("drained_full", 32'(full), 0);

      // 2: dequeue while empty ignored, same-cycle enqueue lands
      dispatch_dequeue = 1'b1;
      commit_enqueue   = 1'b1;
      commit_tag       = 6'd7;
      tick();
      idle();
      check("bypass_tag", 32'(free_reg_tag), 7);
      check("bypass_empty", 32'(empty), 0);
      check("bypass_full", 32'(full), 0);

      // 3: overflow while full, then enqueue paired with dequeue
      do_reset();
      commit_enqueue = 1'b1;
      commit_tag     = 6'd5;
      tick();
      idle();
      check("ovf_set", 32'(overflow_error), 1);
      check("ovf_full", 32'(full), 1);
      check("ovf_tag", 32'(free_reg_tag), 32);
      tick();
      check("ovf_sticky", 32'(overflow_error), 1);
      dispatch_dequeue = 1'b1;
      commit_enqueue   = 1'b1;
      commit_tag       = 6'd5;
      tick();
      commit_enqueue = 1'b0;
      check("swap_full", 32'(full), 1);
      for (int i = 0; i < 31; i++) begin
         check("swap_tag", 32'(free_reg_tag), 32'(33 + i));
         tick();
      end
      dispatch_dequeue = 1'b0;
      check("swap_tag5", 32'(free_reg_tag), 5);
      check("swap_ovf", 32'(overflow_error), 1);

      // 4: save then restore
      do_reset();
      deq_n(3);
      ckpt_save        = 1'b1;
      ckpt_save_column = 2'd2;
      tick();
      idle();
      deq_n(4);
      check("pre_restore", 32'(free_reg_tag), 39);
      ckpt_restore        = 1'b1;
      ckpt_restore_column = 2'd2;
      tick();
      idle();
      check("restore_tag", 32'(free_reg_tag), 35);
      n = 0;
      dispatch_dequeue = 1'b1;
      while (!empty && n < 40) begin
         check("restore_seq", 32'(free_reg_tag), 32'(35 + n));
         tick();
         n++;
      end
      dispatch_dequeue = 1'b0;
      check("restore_count", 32'(n), 29);

      // 5: restore + dequeue + enqueue + save same cycle
      do_reset();
      deq_n(5);
      ckpt_save        = 1'b1;
      ckpt_save_column = 2'd1;
      tick();
      idle();
      deq_n(3);
      check("c5_pre", 32'(free_reg_tag), 40);
      ckpt_restore        = 1'b1;
      ckpt_restore_column = 2'd1;
      dispatch_dequeue    = 1'b1;
      commit_enqueue      = 1'b1;
      commit_tag          = 6'd9;
      ckpt_save           = 1'b1;
      ckpt_save_column    = 2'd3;
      tick();
      idle();
      check("c5_tag", 32'(free_reg_tag), 37);
      check("c5_full", 32'(full), 0);
      deq_n(27);
      check("c5_enq_tag", 32'(free_reg_tag), 9);
      check("c5_not_empty", 32'(empty), 0);
      deq_n(1);
      check("c5_empty", 32'(empty), 1);
      ckpt_restore        = 1'b1;
      ckpt_restore_column = 2'd3;
      tick();
      idle();
      check("c5_col3_tag", 32'(free_reg_tag), 37);
      check("c5_col3_empty", 32'(empty), 0);

      // 6: wraparound with interleaved traffic against a queue model
      do_reset();
      deq_n(32);
      check("c6_empty", 32'(empty), 1);
      for (int i = 0; i < 40; i++) begin
         dispatch_dequeue = (i % 3 != 0);
         commit_enqueue   = 1'b1;
         commit_tag       = 6'((i * 5 + 11) % 64);
         check("c6_empty_flag", 32'(empty), 32'(q.size() == 0));
         if (dispatch_dequeue && q.size() > 0) begin
            check("c6_tag", 32'(free_reg_tag), 32'(q[0]));
            void'(q.pop_front());
         end
         q.push_back(commit_tag);
         tick();
      end
      idle();
      dispatch_dequeue = 1'b1;
      for (int k = 0; k < 40 && q.size() > 0; k++) begin
         check("c6_drain", 32'(free_reg_tag), 32'(q[0]));
         void'(q.pop_front());
         tick();
      end
      dispatch_dequeue = 1'b0;
      check("c6_final_empty", 32'(empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
